// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch and sequencing unit for the 16-bit ISA
//
// Owns the program counter, fetches one instruction word per request over a
// req/ack handshake, presents it to the control unit and picks the next PC
// from the Branch/Jump/Zero inputs when the instruction is accepted.
//
// Optional feature macro: FETCH_HALT_EN
//   defined   : an accepted instruction equal to 16'hFFFF parks the unit in
//               HALT (no further requests, PC frozen) until Reset.
//   undefined : 16'hFFFF is an ordinary opcode-111 instruction.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Imem_Req     out  fetch request to instruction memory
//   Imem_Addr    out  word address of the fetch (always equals PC)
//   Imem_Ack     in   Imem_Data is valid this cycle (ignored while Imem_Req=0)
//   Imem_Data    in   instruction word
//   Stall        in   downstream cannot accept the issued instruction
//   Branch       in   branch request from control unit
//   Zero         in   ALU zero flag
//   Jump         in   jump request from control unit
//   Instr        out  registered current instruction
//   Opcode       out  Instr[15:13]
//   Instr_Valid  out  Instr/Opcode valid for the control unit
//   PC           out  address of the current instruction

module fetch_sequencer #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  output logic                Imem_Req,
  output logic [PC_WIDTH-1:0] Imem_Addr,
  input  logic                Imem_Ack,
  input  logic [15:0]         Imem_Data,
  input  logic                Stall,
  input  logic                Branch,
  input  logic                Zero,
  input  logic                Jump,
  output logic [15:0]         Instr,
  output logic [2:0]          Opcode,
  output logic                Instr_Valid,
  output logic [PC_WIDTH-1:0] PC
);

  // The jump target keeps the PC bits above the 13-bit immediate, so the
  // PC must be wider than the immediate field.
  localparam int JUMP_BITS = 13;
  localparam int OFF_BITS  = 7;

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;
`endif

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                req_q;
  logic [15:0]         instr_q;
  logic                valid_q;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_branch;
  logic [PC_WIDTH-1:0] pc_jump;
  logic [PC_WIDTH-1:0] pc_next;
  logic                accept;
  logic                halt_instr;

  // Next-PC candidates; all additions wrap modulo 2^PC_WIDTH naturally.
  always_comb begin
    pc_inc    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    pc_branch = pc_inc + {{(PC_WIDTH-OFF_BITS){instr_q[OFF_BITS-1]}}, instr_q[OFF_BITS-1:0]};
    pc_jump   = {pc_q[PC_WIDTH-1:JUMP_BITS], instr_q[JUMP_BITS-1:0]};
  end

  // Jump outranks a taken branch.
  always_comb begin
    pc_next = pc_inc;
    if (Jump) begin
      pc_next = pc_jump;
    end else if (Branch && Zero) begin
      pc_next = pc_branch;
    end
  end

  // Branch/Jump/Zero only matter on the single edge that accepts the issued
  // instruction; any stalled cycles before it are ignored.
  assign accept = (state == S_ISSUE) && valid_q && !Stall;

`ifdef FETCH_HALT_EN
  assign halt_instr = (instr_q == 16'hFFFF);
`else
  assign halt_instr = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_q <= 1'b1;
          state <= S_REQ;
        end

        // Request and address stay put until memory acknowledges.
        S_REQ: begin
          if (Imem_Ack) begin
            instr_q <= Imem_Data;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (accept) begin
            valid_q <= 1'b0;
            if (halt_instr) begin
`ifdef FETCH_HALT_EN
              state <= S_HALT;
`endif
            end else begin
              pc_q  <= pc_next;
              req_q <= 1'b1;
              state <= S_REQ;
            end
          end
        end

`ifdef FETCH_HALT_EN
        // Parked until Reset; PC stays at the halt instruction's address.
        S_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
`endif

        default: begin
          state   <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_Req    = req_q;
  assign Imem_Addr   = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Opcode      = instr_q[15:13];
  assign Instr_Valid = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer

module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Imem_Req;
  logic [15:0] Imem_Addr;
  logic        Imem_Ack = 1'b0;
  logic [15:0] Imem_Data = 16'h0000;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump = 1'b0;
  logic [15:0] Instr;
  logic [2:0]  Opcode;
  logic        Instr_Valid;
  logic [15:0] PC;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: address of the instruction being fetched/issued and
  // the instruction word the model expects to be held.
  logic [15:0] exp_pc;
  logic [15:0] exp_instr;
  bit          after_reset;

  fetch_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .Clk(Clk), .Reset(Reset),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
    .Stall(Stall), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .Instr(Instr), .Opcode(Opcode), .Instr_Valid(Instr_Valid), .PC(PC)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Next PC from the ISA rules, using integer arithmetic and masks.
  function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] ins,
                                             input bit b, input bit j, input bit z);
    int off;
    if (j) return (pc & 16'hE000) | (ins & 16'h1FFF);
    if (b && z) begin
      off = int'(ins & 16'h007F);
      if (off >= 64) off = off - 128;
      return 16'((int'(pc) + 1 + off) & 32'hFFFF);
    end
    return 16'((int'(pc) + 1) & 32'hFFFF);
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req"},   Imem_Req, 0);
    check_eq({tag, "_addr"},  Imem_Addr, 16'h0000);
    check_eq({tag, "_pc"},    PC, 16'h0000);
    check_eq({tag, "_instr"}, Instr, 16'h0000);
    check_eq({tag, "_op"},    Opcode, 3'b000);
    check_eq({tag, "_valid"}, Instr_Valid, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Stall = 0; Branch = 0; Jump = 0; Zero = 0; Imem_Ack = 0;
    #1;
    check_reset_values("rst_async");
    @(negedge Clk);
    @(negedge Clk);
    check_reset_values("rst");
    Reset = 1'b0;
    exp_pc = 16'h0000;
    exp_instr = 16'h0000;
    after_reset = 1;
  endtask

  // Serve one fetch with 'waits' unacknowledged cycles, then check issue.
  task automatic fetch(input logic [15:0] data, input int waits);
    int gap = 0;
    while (!Imem_Req && gap < 5) begin
      @(negedge Clk);
      gap++;
    end
    check_eq("req_seen", Imem_Req, 1);
    check_eq("req_gap", gap, after_reset ? 1 : 0);
    after_reset = 0;
    check_eq("fetch_addr", Imem_Addr, exp_pc);
    check_eq("valid_in_req", Instr_Valid, 0);
    for (int w = 0; w < waits; w++) begin
      Imem_Ack = 0;
      Imem_Data = 16'($urandom);
      @(negedge Clk);
      check_eq("req_hold", Imem_Req, 1);
      check_eq("addr_hold", Imem_Addr, exp_pc);
    end
    Imem_Ack = 1;
    Imem_Data = data;
    @(negedge Clk);
    Imem_Ack = 0;
    Imem_Data = 16'($urandom);
    exp_instr = data;
    check_eq("issue_valid", Instr_Valid, 1);
    check_eq("issue_instr", Instr, data);
    check_eq("issue_opcode", Opcode, {29'd0, data[15:13]});
    check_eq("issue_pc", PC, exp_pc);
    check_eq("issue_req", Imem_Req, 0);
  endtask

  // Hold the instruction for 'stalls' cycles with noisy controls, then accept.
  task automatic issue(input int stalls, input bit b, input bit j, input bit z);
    for (int s = 0; s < stalls; s++) begin
      Stall = 1;
      Branch = 1'($urandom); Jump = 1'($urandom); Zero = 1'($urandom);
      @(negedge Clk);
      check_eq("stall_valid", Instr_Valid, 1);
      check_eq("stall_instr", Instr, exp_instr);
      check_eq("stall_pc", PC, exp_pc);
    end
    Stall = 0; Branch = b; Jump = j; Zero = z;
`ifdef FETCH_HALT_EN
    if (exp_instr != 16'hFFFF) exp_pc = model_next(exp_pc, exp_instr, b, j, z);
`else
    exp_pc = model_next(exp_pc, exp_instr, b, j, z);
`endif
    @(negedge Clk);
    Branch = 1'($urandom); Jump = 1'($urandom); Zero = 1'($urandom);
    check_eq("post_accept_valid", Instr_Valid, 0);
  endtask

  initial begin
    exp_pc = 0;
    exp_instr = 0;
    after_reset = 0;

    // Zero-wait sequential fetch of NOPs.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch(16'h0000, 0);
      issue(0, 0, 0, 0);
    end

    // At PC=5: Jump beats Branch.
    fetch(16'h2005, 0);
    issue(0, 1, 1, 1);
    check_eq("jump_wins", Imem_Addr, 16'h0005);

    // Jump to 0x10, branch -2 taken / not taken.
    fetch(16'h2010, 0);
    issue(0, 0, 1, 0);
    fetch(16'h807E, 1);
    issue(0, 1, 0, 1);
    check_eq("branch_taken", Imem_Addr, 16'h000F);
    fetch(16'h2010, 0);
    issue(0, 0, 1, 0);
    fetch(16'h807E, 0);
    issue(0, 1, 0, 0);
    check_eq("branch_not_taken", Imem_Addr, 16'h0011);

    // Stall with toggling controls; only the accept-cycle values count.
    fetch(16'h807E, 2);
    issue(4, 0, 0, 1);
    check_eq("stall_next", Imem_Addr, 16'h0012);

    // Reset during the second wait cycle; late Ack must be ignored.
    fetch(16'h1234, 0);
    issue(0, 0, 0, 0);
    Imem_Ack = 0;
    @(negedge Clk);
    Reset = 1;
    #1;
    check_reset_values("midreq");
    @(negedge Clk);
    Reset = 0;
    Imem_Ack = 1;
    Imem_Data = 16'hABCD;
    @(negedge Clk);
    Imem_Ack = 0;
    check_eq("late_ack_instr", Instr, 16'h0000);
    check_eq("late_ack_valid", Instr_Valid, 0);
    check_eq("restart_addr", Imem_Addr, 16'h0000);
    exp_pc = 0;
    exp_instr = 0;
    fetch(16'h0000, 3);
    issue(0, 0, 0, 0);

    // Wrap: from PC 0 branch -2 lands on 0xFFFF, then +1 wraps to 0.
    do_reset();
    fetch(16'h807E, 0);
    issue(0, 1, 0, 1);
    check_eq("wrap_ffff", Imem_Addr, 16'hFFFF);
    fetch(16'h0000, 0);
    issue(0, 0, 0, 0);
    check_eq("wrap_zero", Imem_Addr, 16'h0000);

    // 16'hFFFF at PC 4.
    fetch(16'h2004, 0);
    issue(0, 0, 1, 0);
    fetch(16'hFFFF, 0);
    issue(0, 0, 0, 0);
`ifdef FETCH_HALT_EN
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      check_eq("halt_req", Imem_Req, 0);
      check_eq("halt_pc", PC, 16'h0004);
      check_eq("halt_valid", Instr_Valid, 0);
    end
`else
    check_eq("ffff_next", Imem_Addr, 16'h0005);
    fetch(16'h0000, 0);
    issue(0, 0, 0, 0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 150; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (d == 16'hFFFF) d = 16'hFFFE;
      fetch(d, int'($urandom_range(0, 3)));
      issue(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
